// File: rtl/uart_receiver.sv
// uart_receiver: asynchronous serial receiver with configurable baud, width,
// parity and bit order. Samples each bit at its midpoint, reports one
// character per frame with parity/framing status.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   rx            serial input, asynchronous, idle high
//   uart_config   baud_rate / data_bits / parity / stop_bits / lsb_first
//   rx_data       last received character (upper unused bits zero)
//   rx_valid      one-cycle pulse when rx_data and error flags update
//   parity_error  last frame had a parity mismatch
//   framing_error last frame's stop bit sampled low
//   busy          receiver is not idle

package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    typedef struct packed {
        logic [2:0] baud_rate;
        logic [1:0] data_bits;   // character width minus 5
        logic [1:0] parity;
        logic       stop_bits;
        logic       lsb_first;
    } uart_config_t;

endpackage

module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 1843200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    input  uart_config_t uart_config,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    output logic         parity_error,
    output logic         framing_error,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(CLK_FREQ / 9600 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         idx, idx_n;
    logic [7:0]         shreg, shreg_n;
    logic               par_pend, par_pend_n;
    logic [7:0]         rx_data_n;
    logic               rx_valid_n, parity_error_n, framing_error_n;
    logic               rx_q1, rx_s;

    logic [CNT_W-1:0]   cpb, half_m1;
    logic [2:0]         dbits_m1, pos;
    logic               bit_done, exp_par;

    // Baud period in clocks; unknown encodings fall back to 9600
    always_comb begin
        case (uart_config.baud_rate)
            BAUD_19200:  cpb = CNT_W'(CLK_FREQ / 19200);
            BAUD_38400:  cpb = CNT_W'(CLK_FREQ / 38400);
            BAUD_57600:  cpb = CNT_W'(CLK_FREQ / 57600);
            BAUD_115200: cpb = CNT_W'(CLK_FREQ / 115200);
            default:     cpb = CNT_W'(CLK_FREQ / 9600);
        endcase
    end

    assign half_m1  = (cpb >> 1) - CNT_W'(1);
    // >= rather than == so a mid-frame config change can never stall the counter
    assign bit_done = (cnt >= cpb - CNT_W'(1));
    assign dbits_m1 = {1'b0, uart_config.data_bits} + 3'd4;
    assign pos      = uart_config.lsb_first ? idx : (dbits_m1 - idx);
    assign exp_par  = (^shreg) ^ (uart_config.parity == PARITY_ODD);

    // Two-flop synchronizer, reset to the idle level
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            par_pend      <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shreg         <= shreg_n;
            par_pend      <= par_pend_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            parity_error  <= parity_error_n;
            framing_error <= framing_error_n;
            busy          <= (state_n != IDLE);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n         = state;
        cnt_n           = cnt + CNT_W'(1);
        idx_n           = idx;
        shreg_n         = shreg;
        par_pend_n      = par_pend;
        rx_data_n       = rx_data;
        rx_valid_n      = 1'b0;
        parity_error_n  = parity_error;
        framing_error_n = framing_error;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit
                if (cnt >= half_m1) begin
                    cnt_n      = '0;
                    idx_n      = '0;
                    shreg_n    = '0;
                    par_pend_n = 1'b0;
                    state_n    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n        = '0;
                    shreg_n[pos] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx >= dbits_m1)
                        state_n = (uart_config.parity != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_n      = '0;
                    par_pend_n = (rx_s != exp_par);
                    state_n    = STOP;
                end
            end
            STOP: begin
                // Only the first stop bit is examined
                if (bit_done) begin
                    cnt_n           = '0;
                    rx_valid_n      = 1'b1;
                    rx_data_n       = shreg;
                    parity_error_n  = par_pend && (uart_config.parity != PARITY_NONE);
                    framing_error_n = !rx_s;
                    state_n         = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives serial frames built from the character and line
// settings, and compares each reported character against the expected one.

module tb_uart_receiver;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 1843200;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx  = 1'b1;
    uart_config_t cfg;
    logic [7:0]   rx_data;
    logic         rx_valid, parity_error, framing_error, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_frames = 0;
    int   pulses = 0;
    int   double_pulses = 0;
    logic prev_valid = 1'b0;
    logic busy_seen = 1'b0;
    res_t got_q[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    uart_receiver #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .uart_config   (cfg),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    // Capture every reported character
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back({rx_data, parity_error, framing_error});
            pulses++;
        end
        if (rx_valid && prev_valid) double_pulses++;
        prev_valid = rx_valid;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bit_cycles(input logic [2:0] code);
        case (code)
            BAUD_19200:  return CLK_FREQ / 19200;
            BAUD_38400:  return CLK_FREQ / 38400;
            BAUD_57600:  return CLK_FREQ / 57600;
            BAUD_115200: return CLK_FREQ / 115200;
            default:     return CLK_FREQ / 9600;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int cyc);
        rx = v;
        repeat (cyc) @(negedge clk);
    endtask

    // Serialise one frame and record what the receiver should report
    task automatic send_frame(input logic [7:0] ch, input int cyc,
                              input bit flip_par, input bit stop_low);
        int         db = int'(cfg.data_bits) + 5;
        logic [7:0] m  = 8'((1 << db) - 1);
        logic [7:0] c  = ch & m;
        logic       p;
        res_t       e;
        e.data = c;
        e.pe   = (cfg.parity != PARITY_NONE) && flip_par;
        e.fe   = stop_low;
        exp_q.push_back(e);
        n_frames++;
        drive_bit(1'b0, cyc);
        for (int i = 0; i < db; i++)
            drive_bit(cfg.lsb_first ? c[i] : c[db-1-i], cyc);
        if (cfg.parity != PARITY_NONE) begin
            p = ^c;
            if (cfg.parity == PARITY_ODD) p = ~p;
            drive_bit(p ^ flip_par, cyc);
        end
        drive_bit(!stop_low, cyc);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input int cyc);
        int   w = 0;
        res_t g, e;
        while (got_q.size() == 0 && w < 4 * cyc) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_pulse"}, 32'(got_q.size() != 0), 32'd1);
        e = exp_q.pop_front();
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            check({tag, "_data"}, 32'(g.data), 32'(e.data));
            check({tag, "_perr"}, 32'(g.pe), 32'(e.pe));
            check({tag, "_ferr"}, 32'(g.fe), 32'(e.fe));
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] ch;
        bit fp, sl;

        cfg = '{baud_rate: BAUD_115200, data_bits: 2'd3, parity: PARITY_NONE,
                stop_bits: 1'b0, lsb_first: 1'b1};

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_data",  32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_perr",  32'(parity_error), 32'd0);
        check("rst_ferr",  32'(framing_error), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 LSB-first 0xA5
        cyc = bit_cycles(cfg.baud_rate);
        send_frame(8'hA5, cyc, 1'b0, 1'b0);
        expect_frame("a5", cyc);
        repeat (2) @(negedge clk);
        check("a5_busy_after", 32'(busy), 32'd0);

        // 7E1 MSB-first 0x53, then with flipped parity
        cfg.data_bits = 2'd2; cfg.parity = PARITY_EVEN; cfg.lsb_first = 1'b0;
        send_frame(8'h53, cyc, 1'b0, 1'b0);
        expect_frame("53e", cyc);
        drive_bit(1'b1, cyc);
        send_frame(8'h53, cyc, 1'b1, 1'b0);
        expect_frame("53e_bad", cyc);
        drive_bit(1'b1, cyc);

        // Framing error, then a clean 0x00
        cfg.data_bits = 2'd3; cfg.parity = PARITY_NONE; cfg.lsb_first = 1'b1;
        send_frame(8'h3C, cyc, 1'b0, 1'b1);
        expect_frame("3c_stop_low", cyc);
        drive_bit(1'b1, cyc);
        send_frame(8'h00, cyc, 1'b0, 1'b0);
        expect_frame("00_after_ferr", cyc);
        drive_bit(1'b1, cyc);

        // Short glitch on an idle line is rejected
        busy_seen = 1'b0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * cyc);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_no_pulse", 32'(got_q.size()), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);

        // Reset during the data bits of 0xFF aborts it
        drive_bit(1'b0, cyc);
        drive_bit(1'b1, 3 * cyc);
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive_bit(1'b1, 12 * cyc);
        check("abort_no_pulse", 32'(got_q.size()), 32'd0);
        check("abort_data_clr", 32'(rx_data), 32'h00);
        send_frame(8'h12, cyc, 1'b0, 1'b0);
        expect_frame("12_after_rst", cyc);
        drive_bit(1'b1, cyc);

        // Back-to-back 5O1 at 9600 with +/-2% sender skew
        cfg = '{baud_rate: BAUD_9600, data_bits: 2'd0, parity: PARITY_ODD,
                stop_bits: 1'b1, lsb_first: 1'b1};
        drive_bit(1'b1, bit_cycles(cfg.baud_rate));
        for (int k = 0; k < 5; k++) begin
            cyc = (bit_cycles(cfg.baud_rate) * ((k % 2 == 0) ? 102 : 98) + 50) / 100;
            send_frame(8'($urandom), cyc, 1'b0, 1'b0);
            expect_frame("skew", cyc);
        end
        drive_bit(1'b1, 2 * bit_cycles(cfg.baud_rate));

        // Randomised frames and line settings
        for (int k = 0; k < 16; k++) begin
            cfg.baud_rate = 3'($urandom_range(2, 4));
            cfg.data_bits = 2'($urandom);
            cfg.parity    = 2'($urandom_range(0, 2));
            cfg.stop_bits = 1'($urandom);
            cfg.lsb_first = 1'($urandom);
            cyc = bit_cycles(cfg.baud_rate);
            drive_bit(1'b1, cyc);
            ch = 8'($urandom);
            fp = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0);
            send_frame(ch, cyc, fp, sl);
            expect_frame("rand", cyc);
            drive_bit(1'b1, cyc + int'($urandom_range(0, 20)));
        end

        check("pulse_count", 32'(pulses), 32'(n_frames));
        check("pulse_width", 32'(double_pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
